// File: rtl/pc_sequencer.sv
// Fetch/decode/execute/advance sequencer driving the program counter's halt/load controls.
// Optional `DEBUG_STEP_EN adds a STEP_WAIT state gated by dbg_step after each instruction.
module pc_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int IR_WIDTH    = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  input  logic                imem_ready,
  input  logic [IR_WIDTH-1:0] imem_rdata,
  output logic [IR_WIDTH-1:0] ir_out,
  output logic                ir_valid,
  input  logic                dec_is_mem,
  input  logic                dec_is_halt,
  input  logic                dec_br_taken,
  input  logic [PC_WIDTH-1:0] dec_target,
  output logic                mem_start,
  input  logic                mem_done,
  input  logic                resume,
  output logic                pc_halt,
  output logic                pc_load_en,
  output logic [PC_WIDTH-1:0] pc_load_val,
  output logic                halted,
  output logic                fault,
  output logic [2:0]          state_dbg,
  input  logic                dbg_step
);
  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2,
    ADVANCE = 3'd3, HALTED = 3'd4, STEP_WAIT = 3'd5
  } state_t;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t                state;
  logic                  is_mem_q;
  logic                  br_q;
  logic [PC_WIDTH-1:0]   target_q;
  logic [CW-1:0]         wait_cnt;

  assign imem_req  = (state == FETCH);
  assign ir_valid  = (state == DECODE);
  assign halted    = (state == HALTED);
  assign state_dbg = state;

`ifndef DEBUG_STEP_EN
  logic unused_dbg_step;
  assign unused_dbg_step = dbg_step;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      ir_out      <= '0;
      fault       <= 1'b0;
      is_mem_q    <= 1'b0;
      br_q        <= 1'b0;
      target_q    <= '0;
      wait_cnt    <= '0;
      mem_start   <= 1'b0;
      pc_halt     <= 1'b1;
      pc_load_en  <= 1'b0;
      pc_load_val <= '0;
    end else begin
      // PC controls are only released for the single cycle spent in ADVANCE
      mem_start   <= 1'b0;
      pc_halt     <= 1'b1;
      pc_load_en  <= 1'b0;
      pc_load_val <= '0;
      case (state)
        FETCH: if (imem_ready) begin
          ir_out <= imem_rdata;
          state  <= DECODE;
        end
        DECODE: begin
          wait_cnt <= '0;
          if (dec_is_halt) begin
            is_mem_q <= 1'b0;
            br_q     <= 1'b0;
            target_q <= '0;
            state    <= HALTED;
          end else begin
            is_mem_q  <= dec_is_mem;
            br_q      <= dec_br_taken;
            target_q  <= dec_target;
            mem_start <= dec_is_mem;
            state     <= EXECUTE;
          end
        end
        EXECUTE: begin
          if (!is_mem_q || mem_done) begin
            pc_halt     <= 1'b0;
            pc_load_en  <= br_q;
            pc_load_val <= br_q ? target_q : '0;
            state       <= ADVANCE;
          end else if (wait_cnt == CW'(MEM_TIMEOUT - 1)) begin
            fault    <= 1'b1;
            br_q     <= 1'b0;
            target_q <= '0;
            state    <= HALTED;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
`ifdef DEBUG_STEP_EN
        ADVANCE:   state <= STEP_WAIT;
        STEP_WAIT: if (dbg_step) state <= FETCH;
`else
        ADVANCE:   state <= FETCH;
        STEP_WAIT: state <= FETCH;
`endif
        // branch state was cleared on entry, so resume always yields PC+1
        HALTED: if (resume && !fault) begin
          pc_halt <= 1'b0;
          state   <= ADVANCE;
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: owns the PC register, a program ROM and a field decoder,
// and checks the sequencer against an instruction-level PC/fault model each cycle.
module tb_pc_sequencer;
  localparam int PW = 8, IW = 16, MT = 15;
`ifdef DEBUG_STEP_EN
  localparam int LAT = 5;
  localparam logic [2:0] POST_ADV = 3'd5;
`else
  localparam int LAT = 4;
  localparam logic [2:0] POST_ADV = 3'd0;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic imem_req, imem_ready, ir_valid;
  logic [IW-1:0] imem_rdata, ir_out;
  logic dec_is_mem, dec_is_halt, dec_br_taken;
  logic [PW-1:0] dec_target, pc_load_val, pc;
  logic mem_start, mem_done, resume, pc_halt, pc_load_en, halted, fault, dbg_step;
  logic [2:0] state_dbg;

  // instruction word: [15]=halt [14]=mem [13]=branch [7:0]=target
  logic [IW-1:0] prog [256];
  int checks = 0, errors = 0;
  int mem_lat = 1, exec_cnt = 0, ms_total = 0;
  int n, ms0;
  logic [PW-1:0] p;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .ir_out(ir_out), .ir_valid(ir_valid),
    .dec_is_mem(dec_is_mem), .dec_is_halt(dec_is_halt), .dec_br_taken(dec_br_taken),
    .dec_target(dec_target), .mem_start(mem_start), .mem_done(mem_done),
    .resume(resume), .pc_halt(pc_halt), .pc_load_en(pc_load_en),
    .pc_load_val(pc_load_val), .halted(halted), .fault(fault),
    .state_dbg(state_dbg), .dbg_step(dbg_step)
  );

  always @(posedge clk)
    if (reset) pc <= '0;
    else if (!pc_halt) pc <= pc_load_en ? pc_load_val : pc + 8'd1;

  assign imem_rdata   = prog[pc];
  assign dec_is_halt  = ir_out[15];
  assign dec_is_mem   = ir_out[14];
  assign dec_br_taken = ir_out[13];
  assign dec_target   = ir_out[7:0];

  // memory answers in the mem_lat-th EXECUTE cycle; mem_lat=0 never answers
  always @(posedge clk) exec_cnt <= (state_dbg == 3'd2 && !reset) ? exec_cnt + 1 : 0;
  assign mem_done = (mem_lat != 0) && (state_dbg == 3'd2) && (exec_cnt + 1 == mem_lat);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    int k = 0;
    while (state_dbg !== s && k < budget) begin @(posedge clk); #1; k++; end
    chk(nm, state_dbg, s);
  endtask

  task automatic wait_pc(input logic [PW-1:0] v, input int budget, input string nm);
    int k = 0;
    while (pc !== v && k < budget) begin @(posedge clk); #1; k++; end
    chk(nm, pc, v);
  endtask

  // instruction-level model: PC moves once per completed instruction
  logic [PW-1:0] m_pc;
  int m_starts, m_exec;
  bit m_fault, m_pend;
  logic [IW-1:0] ins;
  logic exp_en;
  always @(negedge clk) begin
    if (reset) begin
      m_pc = '0; m_starts = 0; m_exec = 0; m_fault = 0; m_pend = 0;
    end else begin
      m_fault = m_fault | m_pend;
      m_pend  = 0;
      ins     = prog[m_pc];
      chk("pc", pc, m_pc);
      chk("fault", fault, m_fault);
      chk("imem_req", imem_req, state_dbg == 3'd0);
      chk("ir_valid", ir_valid, state_dbg == 3'd1);
      chk("halted", halted, state_dbg == 3'd4);
      chk("pc_halt", pc_halt, state_dbg != 3'd3);
      if (!pc_load_en) chk("load_val_zero", pc_load_val, 0);
      if (m_fault) chk("fault_state", state_dbg, 3'd4);
      if (state_dbg == 3'd1) chk("ir_out", ir_out, ins);
      if (mem_start) begin
        ms_total++; m_starts++;
        chk("mem_start_state", state_dbg, 3'd2);
      end
      if (state_dbg == 3'd2) begin
        m_exec++;
        chk("exec_bound", m_exec <= (ins[14] ? MT : 1), 1);
        if (ins[14] && !mem_done && m_exec == MT) m_pend = 1;
      end else m_exec = 0;
      if (state_dbg == 3'd3) begin
        exp_en = ins[13] & ~ins[15];
        chk("load_en", pc_load_en, exp_en);
        chk("load_val", pc_load_val, exp_en ? ins[7:0] : 8'h00);
        chk("mem_start_cnt", m_starts, ins[14]);
        m_starts = 0;
        m_pc = exp_en ? ins[7:0] : m_pc + 8'd1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) prog[i] = '0;
    prog[5]    = 16'h2040;
    prog[8'h40] = 16'h4000;
    prog[8'h41] = 16'h4000;
    imem_ready = 1'b1; resume = 1'b0;
`ifdef DEBUG_STEP_EN
    dbg_step = 1'b1;
`else
    dbg_step = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state_dbg, 0);
    chk("rst_pc_halt", pc_halt, 1);
    chk("rst_load_en", pc_load_en, 0);
    chk("rst_mem_start", mem_start, 0);
    chk("rst_ir", ir_out, 0);
    chk("rst_imem_req", imem_req, 1);
    reset = 1'b0;

    repeat (LAT) @(posedge clk); #1 chk("pc_at_4", pc, 1);
    repeat (LAT) @(posedge clk); #1 chk("pc_at_8", pc, 2);
    repeat (LAT) @(posedge clk); #1 chk("pc_at_12", pc, 3);

    imem_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("fetch_stall_state", state_dbg, 0);
    chk("fetch_stall_pc", pc, 3);
    imem_ready = 1'b1;

    wait_pc(8'h40, 40, "branch_to_40");
    chk("branch_fetch", state_dbg, 0);

    ms0 = ms_total;
    mem_lat = 3;
    wait_state(3'd2, 10, "mem_exec");
    n = 0;
    while (state_dbg == 3'd2 && n < 40) begin n++; @(posedge clk); #1; end
    chk("mem_exec_len", n, 3);
    chk("mem_start_pulses", ms_total - ms0, 1);
    mem_lat = 0;
    wait_pc(8'h41, 10, "mem_pc_inc");

    wait_state(3'd2, 10, "to_exec");
    n = 0;
    while (state_dbg == 3'd2 && n < 40) begin n++; @(posedge clk); #1; end
    chk("timeout_len", n, MT);
    chk("timeout_fault", fault, 1);
    chk("timeout_halted", halted, 1);
    chk("timeout_pc", pc, 8'h41);
    resume = 1'b1; @(posedge clk); #1 resume = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("fault_resume_ignored", state_dbg, 4);
    chk("fault_pc_hold", pc, 8'h41);

    reset = 1'b1; resume = 1'b1;
    prog[0] = 16'h2010; prog[8'h10] = 16'h8000; prog[8'h11] = 16'h4000;
    prog[8'h12] = 16'h20FF; mem_lat = 1;
    @(posedge clk); #1;
    chk("reset_clears_fault", fault, 0);
    chk("reset_beats_resume", state_dbg, 0);
    resume = 1'b0; reset = 1'b0;

    wait_state(3'd4, 40, "halt_entry");
    chk("halt_pc", pc, 8'h10);
    repeat (20) @(posedge clk); #1;
    chk("halt_hold_state", halted, 1);
    chk("halt_hold_pc", pc, 8'h10);
    resume = 1'b1; @(posedge clk); #1 resume = 1'b0;
    chk("resume_advance", state_dbg, 3);
    chk("resume_no_load", pc_load_en, 0);
    @(posedge clk); #1;
    chk("resume_pc", pc, 8'h11);
    chk("resume_next", state_dbg, POST_ADV);

    wait_state(3'd2, 10, "same_cycle_done");
    n = 0;
    while (state_dbg == 3'd2 && n < 40) begin n++; @(posedge clk); #1; end
    chk("same_cycle_len", n, 1);

    wait_pc(8'hFF, 40, "to_ff");
    wait_pc(8'h00, 10, "wrap_00");

    reset = 1'b1; prog[0] = 16'h4000; mem_lat = 0;
    repeat (2) @(posedge clk); #1 reset = 1'b0;
    wait_state(3'd2, 10, "rst_mid_exec");
    repeat (3) @(posedge clk); #1;
    reset = 1'b1; mem_lat = 1;
    @(posedge clk); #1;
    chk("mid_rst_state", state_dbg, 0);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_mem_start", mem_start, 0);
    reset = 1'b0;
    wait_pc(8'h01, 20, "after_mid_rst");

`ifdef DEBUG_STEP_EN
    dbg_step = 1'b0;
    wait_state(3'd5, 20, "step_wait");
    p = pc;
    repeat (5) @(posedge clk); #1;
    chk("step_hold_state", state_dbg, 5);
    chk("step_hold_pc", pc, p);
    dbg_step = 1'b1; @(posedge clk); #1 dbg_step = 1'b0;
    chk("step_fetch", state_dbg, 0);
    wait_state(3'd5, 20, "step_wait2");
    chk("step_one_instr", pc, p + 8'd1);
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle fetch/execute control FSM that drives the 8-bit program counter's load_en, halt and load_val inputs. It handshakes with instruction memory, latches the instruction register, and waits on the data-memory handshake for memory instructions. It decides whether the PC increments, loads a branch target, or freezes for halt or fault.

Parameters:
PC_WIDTH, 8, width of pc_in / pc_load_val
IR_WIDTH, 16, instruction word width
MEM_TIMEOUT, 15, max EXECUTE cycles waiting for mem_done before fault (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; same net as the PC reset
imem_req  output  1  instruction fetch request
imem_ready  input  1  fetch data valid; sampled only while imem_req=1
imem_rdata  input  IR_WIDTH  fetched instruction
ir_out  output  IR_WIDTH  instruction register
ir_valid  output  1  high in DECODE only; the decoder's outputs are sampled then
dec_is_mem  input  1  decoded instruction uses data memory
dec_is_halt  input  1  decoded halt instruction
dec_br_taken  input  1  decoded branch, condition true
dec_target  input  PC_WIDTH  branch target
mem_start  output  1  one-cycle pulse starting a data-memory op
mem_done  input  1  data-memory op complete
resume  input  1  leave HALTED (ignored if fault=1)
pc_halt  output  1  to PC halt
pc_load_en  output  1  to PC load_en
pc_load_val  output  PC_WIDTH  to PC load_val
halted  output  1  FSM in HALTED
fault  output  1  sticky memory-timeout flag
state_dbg  output  3  encoded state
dbg_step  input  1  single-step pulse (used only with DEBUG_STEP_EN)

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXECUTE=2, ADVANCE=3, HALTED=4, STEP_WAIT=5.
- Reset values: state=FETCH; ir_out=0; fault=0; latched decode fields=0; mem_start=0; pc_halt=1; pc_load_en=0; pc_load_val=0; imem_req=1 (combinational from FETCH).
- FETCH: imem_req=1. On a cycle with imem_ready=1, ir_out<=imem_rdata and go to DECODE. Otherwise stay; there is no fetch timeout.
- DECODE: ir_valid=1. Register dec_is_mem, dec_is_halt, dec_br_taken, dec_target.
  - is_halt: go to HALTED. is_halt has priority over the other fields.
  - Otherwise go to EXECUTE.
  - mem_start=1 in the first EXECUTE cycle when is_mem (registered pulse).
- EXECUTE:
  - Non-mem: 1 cycle, then ADVANCE.
  - Mem: wait for mem_done=1, then ADVANCE. A mem_done in the same cycle as mem_start counts.
  - Wait counter counts EXECUTE cycles. If mem_done has not arrived after MEM_TIMEOUT cycles: fault<=1, go to HALTED.
  - mem_done outside EXECUTE is ignored.
- ADVANCE: the only state with pc_halt=0.
  - pc_load_en=latched br_taken; pc_load_val=latched target.
  - Next state is FETCH, or STEP_WAIT if the feature is enabled.
  - pc_load_val=0 whenever pc_load_en=0.
- PC outcome: PC changes exactly once per completed instruction, either +1 (wraps 0xFF->0x00) or to the target. It never changes in any other state.
- HALTED: halted=1, pc_halt=1. The PC keeps pointing at the halt instruction.
  - resume=1 with fault=0: go to ADVANCE with pc_load_en=0, i.e. PC+1. Branch state is cleared on halt entry.
  - With fault=1, only reset exits.
- Minimum instruction latency: 4 cycles (FETCH, DECODE, EXECUTE, ADVANCE) with imem_ready and mem_done immediate.
- Reset mid-operation: any state returns to FETCH next cycle. Any pending mem op is abandoned, and mem_start is not reissued until a new EXECUTE.
- Simultaneous resume and reset: reset wins.

Optional Feature:
DEBUG_STEP_EN
- Defined: ADVANCE goes to STEP_WAIT. STEP_WAIT holds pc_halt=1 and waits for dbg_step=1, then goes to FETCH. A dbg_step held high advances one instruction per visit to STEP_WAIT. dbg_step in other states is ignored.
- Undefined: STEP_WAIT is unreachable, ADVANCE goes directly to FETCH, and dbg_step is ignored. The port remains present.

Test Plan:
- Reset, then imem_ready=1 every cycle, non-mem, non-branch instructions -> PC 0,1,2,3 at cycles 4,8,12 after reset release; pc_halt=0 only in ADVANCE.
- Branch: dec_br_taken=1, dec_target=0x40 at PC=5 -> single ADVANCE cycle with pc_load_en=1, pc_load_val=0x40; next FETCH at PC=0x40.
- Mem instruction with mem_done after 3 cycles -> mem_start single pulse; EXECUTE lasts 3 cycles; PC+1. Repeat with mem_done never asserted -> after 15 EXECUTE cycles fault=1, halted=1, PC unchanged; resume has no effect; reset clears fault.
- Halt at PC=0x10 -> halted=1, PC stays 0x10 for 20 cycles; resume pulse -> one ADVANCE, PC=0x11, FETCH.
- PC=0xFF non-branch -> wraps to 0x00. Reset asserted during EXECUTE of a mem op -> state_dbg=0 and PC=0 next cycle, mem_start=0.
- DEBUG_STEP_EN defined: after ADVANCE, state_dbg=5 until dbg_step pulse; PC advances exactly one instruction per pulse.
